// File: rtl/key_entry_display.sv
`default_nettype none
// ============================================================================
// Module      : key_entry_display
// Description : Debounces keypad codes into single events, edits a 4-digit
//               BCD entry buffer and multiplexes it onto a 7-segment display.
// Revision    : 1.0 - initial release
// ============================================================================
module key_entry_display #(
    parameter int SCAN_DIV      = 100000,
    parameter int STABLE_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_in,
    output logic [15:0] digits,
    output logic [2:0]  count,
    output logic [15:0] guess,
    output logic        guess_valid,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int c_STAB_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int c_SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_STAB_W-1:0] c_STAB_MAX = c_STAB_W'(STABLE_CYCLES - 1);
    localparam logic [c_SCAN_W-1:0] c_SCAN_MAX = c_SCAN_W'(SCAN_DIV - 1);

    localparam logic [3:0] c_KEY_NONE   = 4'hF;
    localparam logic [3:0] c_KEY_BACK   = 4'hE;
    localparam logic [3:0] c_KEY_CLEAR  = 4'hC;
    localparam logic [3:0] c_KEY_SUBMIT = 4'hA;
    localparam logic [2:0] c_FULL       = 3'd4;

    // ------------------------------------------------------------------
    // Key sampling and stability filter
    // ------------------------------------------------------------------
    logic [3:0]          r_key_q;
    logic [3:0]          r_last_key;
    logic [c_STAB_W-1:0] r_stab_cnt;
    logic                w_event;

    assign w_event = (r_stab_cnt == c_STAB_MAX) && (r_key_q != r_last_key);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_q    <= c_KEY_NONE;
            r_last_key <= c_KEY_NONE;
            r_stab_cnt <= '0;
        end else begin
            r_key_q <= key_in;
            if (key_in != r_key_q) begin
                r_stab_cnt <= '0;
            end else if (r_stab_cnt != c_STAB_MAX) begin
                r_stab_cnt <= r_stab_cnt + 1'b1;
            end
            if (w_event) begin
                r_last_key <= r_key_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry buffer editing
    // ------------------------------------------------------------------
    logic [15:0] r_digits;
    logic [2:0]  r_count;
    logic [15:0] r_guess;
    logic        r_guess_valid;
    logic [15:0] w_digits_nxt;
    logic [2:0]  w_count_nxt;
    logic        w_submit;

    always_comb begin
        w_digits_nxt = r_digits;
        w_count_nxt  = r_count;
        w_submit     = 1'b0;
        if (w_event) begin
            if (r_key_q <= 4'd9) begin
                if (r_count < c_FULL) begin
                    w_digits_nxt = {r_digits[11:0], r_key_q};
                    w_count_nxt  = r_count + 3'd1;
                end
            end else begin
                case (r_key_q)
                    c_KEY_BACK: begin
                        if (r_count != 3'd0) begin
                            w_digits_nxt = {4'h0, r_digits[15:4]};
                            w_count_nxt  = r_count - 3'd1;
                        end
                    end
                    c_KEY_CLEAR: begin
                        w_digits_nxt = '0;
                        w_count_nxt  = 3'd0;
                    end
                    c_KEY_SUBMIT: begin
                        if (r_count == c_FULL) begin
                            w_submit     = 1'b1;
                            w_digits_nxt = '0;
                            w_count_nxt  = 3'd0;
                        end
                    end
                    // Release (F) and reserved codes leave the buffer alone
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digits      <= '0;
            r_count       <= 3'd0;
            r_guess       <= '0;
            r_guess_valid <= 1'b0;
        end else begin
            r_digits      <= w_digits_nxt;
            r_count       <= w_count_nxt;
            r_guess_valid <= w_submit;
            if (w_submit) begin
                r_guess <= r_digits;
            end
        end
    end

    // ------------------------------------------------------------------
    // Display multiplexing
    // ------------------------------------------------------------------
    logic [c_SCAN_W-1:0] r_scan_cnt;
    logic [1:0]          r_idx;
    logic [3:0]          r_an;
    logic [6:0]          r_seg;
    logic [3:0]          w_nibble;
    logic                w_lit;
    logic [6:0]          w_seg_code;

    assign w_nibble = r_digits[{r_idx, 2'b00} +: 4];
    assign w_lit    = ({1'b0, r_idx} < r_count);

    always_comb begin
        w_seg_code = 7'b1111111;
        case (w_nibble)
            4'd0:    w_seg_code = 7'b1000000;
            4'd1:    w_seg_code = 7'b1111001;
            4'd2:    w_seg_code = 7'b0100100;
            4'd3:    w_seg_code = 7'b0110000;
            4'd4:    w_seg_code = 7'b0011001;
            4'd5:    w_seg_code = 7'b0010010;
            4'd6:    w_seg_code = 7'b0000010;
            4'd7:    w_seg_code = 7'b1111000;
            4'd8:    w_seg_code = 7'b0000000;
            4'd9:    w_seg_code = 7'b0010000;
            default: w_seg_code = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_idx      <= 2'd0;
            r_an       <= 4'b1111;
            r_seg      <= 7'b1111111;
        end else begin
            if (r_scan_cnt == c_SCAN_MAX) begin
                r_scan_cnt <= '0;
                r_idx      <= r_idx + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            // Positions beyond the entered digit count stay dark
            if (w_lit) begin
                r_an  <= ~(4'b0001 << r_idx);
                r_seg <= w_seg_code;
            end else begin
                r_an  <= 4'b1111;
                r_seg <= 7'b1111111;
            end
        end
    end

    assign digits      = r_digits;
    assign count       = r_count;
    assign guess       = r_guess;
    assign guess_valid = r_guess_valid;
    assign an          = r_an;
    assign seg         = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_key_entry_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_entry_display
// Description : Directed self-checking bench for key_entry_display.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_entry_display;

    localparam int STABLE = 4;
    localparam int SCAN   = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  key_in;
    logic [15:0] digits;
    logic [2:0]  count;
    logic [15:0] guess;
    logic        guess_valid;
    logic [3:0]  an;
    logic [6:0]  seg;

    int errors;
    int checks;
    int strobes;
    int double_hi;
    logic prev_gv;

    key_entry_display #(
        .SCAN_DIV      (SCAN),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .digits      (digits),
        .count       (count),
        .guess       (guess),
        .guess_valid (guess_valid),
        .an          (an),
        .seg         (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        strobes   = 0;
        double_hi = 0;
        prev_gv   = 1'b0;
    end

    always @(negedge clk) begin
        if (guess_valid === 1'b1) begin
            strobes = strobes + 1;
            if (prev_gv === 1'b1) double_hi = double_hi + 1;
        end
        prev_gv = guess_valid;
    end

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_in = k;
        repeat (8) @(negedge clk);
        key_in = 4'hF;
        repeat (8) @(negedge clk);
    endtask

    task automatic check_buf(input string name, input logic [15:0] exp_d, input logic [2:0] exp_c);
        checks++;
        if (digits !== exp_d) begin
            errors++;
            $display("FAIL %s digits: got %h expected %h", name, digits, exp_d);
        end
        checks++;
        if (count !== exp_c) begin
            errors++;
            $display("FAIL %s count: got %0d expected %0d", name, count, exp_c);
        end
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        key_in = 4'hF;
        repeat (3) @(negedge clk);
        check_buf("reset", 16'h0000, 3'd0);
        checks++;
        if (guess !== 16'h0000) begin errors++; $display("FAIL reset guess: got %h expected 0000", guess); end
        checks++;
        if (guess_valid !== 1'b0) begin errors++; $display("FAIL reset guess_valid: got %b expected 0", guess_valid); end
        checks++;
        if (an !== 4'b1111) begin errors++; $display("FAIL reset an: got %b expected 1111", an); end
        checks++;
        if (seg !== 7'b1111111) begin errors++; $display("FAIL reset seg: got %b expected 1111111", seg); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_entry;
        press(4'hF);
        press(4'h1);
        press(4'h2);
        press(4'h3);
        press(4'h4);
        check_buf("entry_1234", 16'h1234, 3'd4);
        press(4'h5);
        check_buf("entry_full", 16'h1234, 3'd4);
    endtask

    task automatic test_edit_submit;
        int s0;
        press(4'hE);
        check_buf("backspace", 16'h0123, 3'd3);
        s0 = strobes;
        press(4'hA);
        checks++;
        if (strobes != s0) begin errors++; $display("FAIL submit_short strobes: got %0d expected 0", strobes - s0); end
        check_buf("submit_short", 16'h0123, 3'd3);
        press(4'h9);
        check_buf("entry_1239", 16'h1239, 3'd4);
        s0 = strobes;
        press(4'hA);
        checks++;
        if (strobes - s0 != 1) begin errors++; $display("FAIL submit strobes: got %0d expected 1", strobes - s0); end
        checks++;
        if (double_hi != 0) begin errors++; $display("FAIL submit double_strobe: got %0d expected 0", double_hi); end
        checks++;
        if (guess !== 16'h1239) begin errors++; $display("FAIL submit guess: got %h expected 1239", guess); end
        check_buf("submit_clear", 16'h0000, 3'd0);
    endtask

    task automatic test_no_repeat;
        @(negedge clk);
        key_in = 4'h7;
        repeat (3 * STABLE + 8) @(negedge clk);
        check_buf("hold_7", 16'h0007, 3'd1);
        key_in = 4'hF;
        repeat (8) @(negedge clk);
        press(4'h7);
        check_buf("repress_7", 16'h0077, 3'd2);
    endtask

    task automatic test_glitch_clear;
        @(negedge clk);
        key_in = 4'h5;
        repeat (2) @(negedge clk);
        key_in = 4'hF;
        repeat (10) @(negedge clk);
        check_buf("glitch", 16'h0077, 3'd2);
        press(4'h1);
        check_buf("entry_771", 16'h0771, 3'd3);
        press(4'hC);
        check_buf("clear", 16'h0000, 3'd0);
    endtask

    task automatic test_display;
        logic [3:0] an_s [32];
        logic [6:0] seg_s[32];
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int start;
        press(4'h4);
        press(4'h2);
        check_buf("disp_setup", 16'h0042, 3'd2);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            an_s[i]  = an;
            seg_s[i] = seg;
        end
        start = -1;
        for (int i = 1; i < 17; i++) begin
            if (start < 0 && an_s[i] === 4'b1110 && an_s[i-1] !== 4'b1110) start = i;
        end
        checks++;
        if (start < 0) begin
            errors++;
            $display("FAIL display_sync: got an=%b expected a 1110 phase within 16 cycles", an_s[0]);
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (k < 4) begin
                    exp_an = 4'b1110; exp_seg = 7'b0100100;
                end else if (k < 8) begin
                    exp_an = 4'b1101; exp_seg = 7'b0011001;
                end else begin
                    exp_an = 4'b1111; exp_seg = 7'b1111111;
                end
                checks++;
                if (an_s[start+k] !== exp_an || seg_s[start+k] !== exp_seg) begin
                    errors++;
                    $display("FAIL display_phase%0d: got an=%b seg=%b expected an=%b seg=%b",
                             k, an_s[start+k], seg_s[start+k], exp_an, exp_seg);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        press(4'h3);
        check_buf("pre_reset", 16'h0423, 3'd3);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_buf("async_reset", 16'h0000, 3'd0);
        checks++;
        if (guess !== 16'h0000) begin errors++; $display("FAIL async_reset guess: got %h expected 0000", guess); end
        checks++;
        if (an !== 4'b1111 || seg !== 7'b1111111) begin
            errors++;
            $display("FAIL async_reset display: got an=%b seg=%b expected 1111 1111111", an, seg);
        end
        checks++;
        if (guess_valid !== 1'b0) begin errors++; $display("FAIL async_reset guess_valid: got %b expected 0", guess_valid); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        press(4'h8);
        check_buf("after_reset", 16'h0008, 3'd1);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        key_in = 4'hF;
        test_reset();
        test_entry();
        test_edit_submit();
        test_no_repeat();
        test_glitch_clear();
        test_display();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
